// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states,
// default latencies and the fixed divide-by-zero quotient.
// Ports: none (package).
package mdu_pkg;

    // Op[1] selects divide, Op[0] selects unsigned
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 33;   // 32 divider steps + 1 sign-fix cycle

    // Latency counter width; holds MUL_CYCLES-1 for multiplies up to 256 cycles
    localparam int CNT_W = 8;

    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    // Magnitude of an operand; only signed ops take the two's complement
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Unsigned 32-step restoring divider, one shift-subtract step per cycle.
// Latency: 32 cycles from load to done; load restarts any divide in progress.
// Backpressure: none; done stays high until the next load.
// Ports: Clk/Reset shared with the parent; load_i captures dividend_i/divisor_i;
//        quotient_o/remainder_o are valid while done_o is high.
module div_core
    import mdu_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        done_o
);

    logic [31:0] rem_q;     // partial remainder
    logic [31:0] quo_q;     // dividend bits shift out the top, quotient bits in at the bottom
    logic [31:0] dvs_q;
    logic [4:0]  step_q;
    logic        run_q;
    logic        done_q;

    logic [32:0] part_d;
    logic [32:0] diff_d;

    // Shift the next dividend bit into the remainder and trial-subtract.
    // A divisor of zero always "fits", giving an all-ones quotient and
    // leaving the dividend as the remainder.
    assign part_d = {rem_q, quo_q[31]};
    assign diff_d = part_d - {1'b0, dvs_q};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (load_i) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            dvs_q  <= divisor_i;
            step_q <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            if (!diff_d[32]) begin
                rem_q <= diff_d[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= part_d[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
            step_q <= step_q + 1'b1;
            if (step_q == 5'd31) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign done_o      = done_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Latency: MUL_CYCLES for multiplies, 33 for divides; result lands on the edge Busy falls.
// Backpressure: Busy (registered) stalls the pipeline; Start/HIWrite/LOWrite ignored while Busy.
// Ports: Clk, Reset (async active-low), Start/Op/A/B launch an op, HIWrite/LOWrite
//        load HI/LO from A when idle, Busy/HI/LO are registered outputs.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // Divide latency is set by the 32-step core plus the fix cycle, not tunable
    localparam int DIV_CYCLES = DEF_DIV_CYCLES;

    // The counter expires on the edge that leaves MUL (commit) or DIV (into FIX)
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      a_q, b_q;
    logic             mul_signed_q;
    logic             q_neg_q;     // quotient sign differs from unsigned result
    logic             r_neg_q;     // remainder follows the dividend sign
    logic             dz_q;        // divide by zero latched at launch

    logic             accept_d;
    logic             op_signed_d;
    logic [63:0]      mul_a_d, mul_b_d, prod_d;
    logic [31:0]      core_quo, core_rem;
    logic             core_done;
    logic [31:0]      quo_fix_d, rem_fix_d;

    assign accept_d    = (state_q == IDLE) && Start;
    assign op_signed_d = ~Op[0];

    // Sign/zero-extended 64-bit operands make a plain 64-bit product exact
    // in its low 64 bits for both MULT and MULTU.
    assign mul_a_d = mul_signed_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign mul_b_d = mul_signed_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign prod_d  = mul_a_d * mul_b_d;

    div_core u_div_core (
        .Clk         (Clk),
        .Reset       (Reset),
        .load_i      (accept_d && Op[1]),
        .dividend_i  (mag32(A, op_signed_d)),
        .divisor_i   (mag32(B, op_signed_d)),
        .quotient_o  (core_quo),
        .remainder_o (core_rem),
        .done_o      (core_done)
    );

    // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000
    // negates to itself and the remainder is zero.
    assign quo_fix_d = q_neg_q ? -core_quo : core_quo;
    assign rem_fix_d = r_neg_q ? -core_rem : core_rem;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            dz_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        // Start takes priority; same-cycle MTHI/MTLO are dropped
                        a_q          <= A;
                        b_q          <= B;
                        mul_signed_q <= op_signed_d;
                        q_neg_q      <= op_signed_d & (A[31] ^ B[31]);
                        r_neg_q      <= op_signed_d & A[31];
                        dz_q         <= (B == 32'd0);
                        busy_q       <= 1'b1;
                        if (Op[1]) begin
                            state_q <= DIV;
                            cnt_q   <= DIV_LOAD;
                        end else begin
                            state_q <= MUL;
                            cnt_q   <= MUL_LOAD;
                        end
                    end else begin
                        if (HIWrite) hi_q <= A;
                        if (LOWrite) lo_q <= A;
                    end
                end
                MUL: begin
                    if (cnt_q == '0) begin
                        hi_q    <= prod_d[63:32];
                        lo_q    <= prod_d[31:0];
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DIV: begin
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    // The core finishes its last step on the edge entering FIX
                    if (core_done) begin
                        if (dz_q) begin
                            lo_q <= DIV_ZERO_QUO;
                            hi_q <= a_q;
                        end else begin
                            lo_q <= quo_fix_d;
                            hi_q <= rem_fix_d;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A, B;
    logic        HIWrite, LOWrite;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks   = 0;
    int failures = 0;

    // Bench's own view of the architectural HI/LO
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    mult_div_unit #(.MUL_CYCLES(5)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .HIWrite (HIWrite),
        .LOWrite (LOWrite),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference arithmetic straight from the instruction semantics
    function automatic void ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = 64'(sp);
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {hi, lo} = up;
            end
            OP_DIV: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'h0;
                end else begin
                    sa = a; sb = b;
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Count edges until Busy falls; lat=k means Busy low after edge t0+k
    task automatic wait_idle(input string name, output int lat);
        lat = 0;
        while (Busy && lat < 200) begin
            if (lat == 1) begin
                check32({name, "_hold_hi"}, HI, mdl_hi);
                check32({name, "_hold_lo"}, LO, mdl_lo);
            end
            tick();
            lat++;
        end
        if (lat >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        Start = 1'b1; Op = op; A = a; B = b;
        tick();
        Start = 1'b0;
        A = $urandom; B = $urandom;   // operands must already be latched
        check32({name, "_busy"}, {31'b0, Busy}, 32'd1);
        wait_idle(name, lat);
        check_int({name, "_lat"}, lat, op[1] ? 33 : 5);
        check32({name, "_hi"}, HI, ehi);
        check32({name, "_lo"}, LO, elo);
        mdl_hi = ehi;
        mdl_lo = elo;
    endtask

    initial begin
        int          lat;
        logic [1:0]  rop;
        logic [31:0] ra, rb, rhi, rlo;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
        vecs[4] = '{OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF};
        vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
        vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        vecs[7] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[9] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};

        Reset = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0;
        HIWrite = 1'b0; LOWrite = 1'b0;
        #2;
        check32("reset_busy", {31'b0, Busy}, 32'd0);
        check32("reset_hi", HI, 32'd0);
        check32("reset_lo", LO, 32'd0);
        #10 Reset = 1'b1;
        tick();

        // Table-driven directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // MTHI+MTLO together in IDLE, then MTHI alone
        A = 32'h55AA; HIWrite = 1'b1; LOWrite = 1'b1;
        tick();
        HIWrite = 1'b0; LOWrite = 1'b0;
        check32("mt_both_hi", HI, 32'h55AA);
        check32("mt_both_lo", LO, 32'h55AA);
        A = 32'h1111; HIWrite = 1'b1;
        tick();
        HIWrite = 1'b0;
        check32("mthi_only_hi", HI, 32'h1111);
        check32("mthi_only_lo", LO, 32'h55AA);
        mdl_hi = 32'h1111; mdl_lo = 32'h55AA;

        // MTHI/MTLO while busy are ignored
        Start = 1'b1; Op = OP_DIVU; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0; A = 32'h1234; HIWrite = 1'b1; LOWrite = 1'b1;
        wait_idle("mt_busy", lat);
        HIWrite = 1'b0; LOWrite = 1'b0;
        check_int("mt_busy_lat", lat, 33);
        check32("mt_busy_hi", HI, 32'd2);
        check32("mt_busy_lo", LO, 32'd14);
        mdl_hi = 32'd2; mdl_lo = 32'd14;

        // Start and MTLO in the same cycle: MTLO dropped
        Start = 1'b1; Op = OP_MULTU; A = 32'd2; B = 32'd3; LOWrite = 1'b1;
        tick();
        Start = 1'b0; LOWrite = 1'b0;
        check32("start_mtlo_lo", LO, 32'd14);
        wait_idle("start_mtlo", lat);
        check_int("start_mtlo_lat", lat, 5);
        check32("start_mtlo_res_hi", HI, 32'd0);
        check32("start_mtlo_res_lo", LO, 32'd6);
        mdl_hi = 32'd0; mdl_lo = 32'd6;

        // Start held high: second op only after one IDLE cycle
        Start = 1'b1; Op = OP_MULT; A = 32'hFFFF_FFFE; B = 32'd3;
        tick();
        Op = OP_MULTU; A = 32'd7; B = 32'd6;
        wait_idle("b2b_first", lat);
        check_int("b2b_first_lat", lat, 5);
        check32("b2b_first_hi", HI, 32'hFFFF_FFFF);
        check32("b2b_first_lo", LO, 32'hFFFF_FFFA);
        mdl_hi = 32'hFFFF_FFFF; mdl_lo = 32'hFFFF_FFFA;
        tick();
        Start = 1'b0;
        check32("b2b_second_busy", {31'b0, Busy}, 32'd1);
        wait_idle("b2b_second", lat);
        check_int("b2b_second_lat", lat, 5);
        check32("b2b_second_hi", HI, 32'd0);
        check32("b2b_second_lo", LO, 32'd42);
        mdl_hi = 32'd0; mdl_lo = 32'd42;

        // Reset mid-divide clears everything immediately
        Start = 1'b1; Op = OP_DIV; A = 32'hFFFF_FFF9; B = 32'd2;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2 Reset = 1'b0;
        #1;
        check32("midreset_busy", {31'b0, Busy}, 32'd0);
        check32("midreset_hi", HI, 32'd0);
        check32("midreset_lo", LO, 32'd0);
        mdl_hi = '0; mdl_lo = '0;
        @(posedge Clk);
        #3 Reset = 1'b1;
        tick();
        run_op("post_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            ref_md(rop, ra, rb, rhi, rlo);
            run_op($sformatf("rand%0d", i), rop, ra, rb, rhi, rlo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
